w7_ram_loader: RTL and testbench
================================

Name: w7_ram_loader

Overview:
- Writer side of the layer-7 weight store: accepts a 16-bit weight word stream over a valid/ready handshake.
- Packs each group of 5 words into one 80-bit row.
- Writes rows sequentially into the 128x80 weight RAM on the port that the 80-bit, 7-bit-address read side consumes.
- Runs once per weight reload, triggered by the top-level controller; signals completion with a one-cycle done pulse.

Parameters:
- DATA_W, 16, width of one input weight word.
- WORDS_PER_ROW, 5, words packed per RAM row (DATA_W*WORDS_PER_ROW = 80).
- ADDR_W, 7, RAM address width.
- DEPTH, 120, number of rows written per load (1..2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle load request; sampled only in IDLE.
- in_data  input  DATA_W  weight word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- w7_we  output  1  RAM write enable, one-cycle pulse per row.
- w7_waddr  output  ADDR_W  RAM write address.
- w7_wdata  output  DATA_W*WORDS_PER_ROW  RAM write data.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse after the last row is written.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; in_ready, w7_we, w7_waddr, w7_wdata, busy, done, word counter and row counter all 0. Reset mid-load aborts with no further writes; the partial row is discarded.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: in_ready=0. If start=1, go to LOAD, clear the word counter and row counter, and set busy=1 next cycle.
- LOAD: in_ready=1.
  - A word is accepted on a cycle with in_valid&in_ready.
  - Word k (k=0..4) of the row is stored at pack bits [k*DATA_W +: DATA_W]; the first word lands in the LSBs.
  - On acceptance of word 4, go to WRITE.
  - in_valid=0 stalls indefinitely with no timeout.
- WRITE (exactly 1 cycle): in_ready=0; w7_we=1; w7_waddr=row counter; w7_wdata=full pack register. All three are registered outputs, valid in the same cycle.
  - Latency: last word accepted in cycle t produces w7_we=1 in cycle t+1.
  - Next state: if row counter == DEPTH-1, go to DONE; else increment the row counter, clear the word counter, and go to LOAD.
  - Throughput is 1 row per 6 cycles at full input rate.
- DONE (1 cycle): done=1; busy=0 from the following cycle; next state IDLE. in_ready=0.
- busy=1 in LOAD and WRITE, and in DONE.
- w7_we is 0 in all states except WRITE. w7_waddr and w7_wdata hold their last values outside WRITE.
- start while not IDLE is ignored, with no restart.
- in_data while in_ready=0 is ignored.
- Row counter never wraps within a load; it stops at DEPTH-1.
- With DEPTH=2**ADDR_W, the last address is all-ones; no overflow.
- start and in_valid asserted in the same IDLE cycle: start is taken, but the word is not accepted (in_ready=0 that cycle).

Decomposition:
- Shared package holds W7_DATA_W=16, W7_WORDS_PER_ROW=5, W7_ADDR_W=7, W7_DEPTH=120 and the state encoding (2-bit: IDLE=0, LOAD=1, WRITE=2, DONE=3). The read-side wrapper and this loader both reference these constants.
- No sub-module: the packer shift/index logic is inline. The RAM itself is instantiated at top level, not inside the loader.

Test Plan:
- Reset mid-load: assert rst_n=0 during LOAD after 3 words of row 2 -> all outputs 0 immediately, no w7_we thereafter; a new start reloads from w7_waddr=0.
- Single row, DEPTH=1: start, then words 0x0001,0x0002,0x0003,0x0004,0x0005 back-to-back -> one cycle after the 5th accept, w7_we=1, w7_waddr=0, w7_wdata=0x0005_0004_0003_0002_0001. done pulses the next cycle, and busy drops the cycle after that.
- Full load, DEPTH=120, continuous valid, word value = index -> 120 writes at addresses 0..119, each 6 cycles apart. Row r holds words 5r..5r+4 LSB-first. Exactly one done pulse, and in_ready=0 on every WRITE cycle.
- Random in_valid gaps (30% idle) -> same RAM contents as the continuous case; no word dropped or duplicated; a scoreboard compares all 120 rows.
- start pulsed during LOAD and WRITE, and in_valid=1 while IDLE -> no restart, no extra accept. w7_waddr sequence is unchanged and in_ready stays 0 in IDLE.
- DEPTH=128 parameter run -> last write at w7_waddr=7'h7F, then done; no write to address 0 after wrap.

Source files
------------

// File: rtl/w7_ram_loader_pkg.sv
// Shared constants and state encoding for the layer-7 weight store.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Used by the loader (writer side) and by the read-side wrapper so both
// agree on row width, address width and number of rows per load.
package w7_ram_loader_pkg;

    localparam int W7_DATA_W        = 16;
    localparam int W7_WORDS_PER_ROW = 5;
    localparam int W7_ADDR_W        = 7;
    localparam int W7_DEPTH         = 120;
    localparam int W7_ROW_W         = W7_DATA_W * W7_WORDS_PER_ROW;

    // Loader FSM encoding.
    typedef enum logic [1:0] {
        W7_IDLE  = 2'd0,
        W7_LOAD  = 2'd1,
        W7_WRITE = 2'd2,
        W7_DONE  = 2'd3
    } w7_state_e;

endpackage

// File: rtl/w7_ram_loader.sv
// Weight RAM loader: packs WORDS_PER_ROW input words into one row and writes rows 0..DEPTH-1.
// Latency: row write (w7_we) one cycle after the last word of the row is accepted; done one cycle after the last write.
// Backpressure: in_ready is high only in LOAD; it drops for the single WRITE cycle, so full rate is 1 row / (WORDS_PER_ROW+1) cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle load request, honoured only in IDLE
//   in_data/in_valid    weight word stream; in_ready = word accepted this cycle
//   w7_we/w7_waddr/w7_wdata  registered RAM write port (one pulse per row)
//   busy                high from the cycle after start up to and including the done cycle
//   done                one-cycle pulse after the last row is written
module w7_ram_loader
    import w7_ram_loader_pkg::*;
#(
    parameter int DATA_W        = W7_DATA_W,
    parameter int WORDS_PER_ROW = W7_WORDS_PER_ROW,
    parameter int ADDR_W        = W7_ADDR_W,
    parameter int DEPTH         = W7_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            w7_we,
    output logic [ADDR_W-1:0]               w7_waddr,
    output logic [DATA_W*WORDS_PER_ROW-1:0] w7_wdata,
    output logic                            busy,
    output logic                            done
);

    localparam int ROW_W = DATA_W * WORDS_PER_ROW;
    localparam int CNT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(DEPTH - 1);

    w7_state_e          state_q,    state_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]  row_cnt_q,  row_cnt_d;
    logic [ROW_W-1:0]   pack_q,     pack_d;
    logic               in_ready_q, in_ready_d;
    logic               we_q,       we_d;
    logic [ADDR_W-1:0]  waddr_q,    waddr_d;
    logic [ROW_W-1:0]   wdata_q,    wdata_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               accept;

    // in_ready_q is itself only high in LOAD, but qualifying with the state
    // keeps the accept condition obviously tied to the FSM.
    assign accept = (state_q == W7_LOAD) && in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        row_cnt_d  = row_cnt_q;
        pack_d     = pack_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            W7_IDLE: begin
                if (start) begin
                    state_d    = W7_LOAD;
                    word_cnt_d = '0;
                    row_cnt_d  = '0;
                end
            end

            W7_LOAD: begin
                if (accept) begin
                    // First word of a row lands in the LSBs.
                    for (int k = 0; k < WORDS_PER_ROW; k++) begin
                        if (word_cnt_q == CNT_W'(k)) begin
                            pack_d[k*DATA_W +: DATA_W] = in_data;
                        end
                    end
                    if (word_cnt_q == LAST_WORD) begin
                        // Capture the completed row (including this word)
                        // straight into the write-port registers.
                        state_d = W7_WRITE;
                        waddr_d = row_cnt_q;
                        wdata_d = pack_d;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end

            W7_WRITE: begin
                // Row counter stops at the last row rather than wrapping,
                // so DEPTH == 2**ADDR_W never revisits address 0.
                if (row_cnt_q == LAST_ROW) begin
                    state_d = W7_DONE;
                end else begin
                    state_d    = W7_LOAD;
                    row_cnt_d  = row_cnt_q + ADDR_W'(1);
                    word_cnt_d = '0;
                end
            end

            W7_DONE: begin
                state_d = W7_IDLE;
            end

            default: begin
                state_d = W7_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so that they are
        // registered yet line up exactly with the state they describe.
        in_ready_d = (state_d == W7_LOAD);
        we_d       = (state_d == W7_WRITE);
        busy_d     = (state_d != W7_IDLE);
        done_d     = (state_d == W7_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= W7_IDLE;
            word_cnt_q <= '0;
            row_cnt_q  <= '0;
            pack_q     <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            row_cnt_q  <= row_cnt_d;
            pack_q     <= pack_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign w7_we    = we_q;
    assign w7_waddr = waddr_q;
    assign w7_wdata = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_w7_ram_loader.sv
// Directed bench for w7_ram_loader: three instances (DEPTH=1, 120, 128)
// share clock, reset and the word stream; each has its own start, and only
// the instance selected by sel is exercised at any time.
module tb_w7_ram_loader;
    import w7_ram_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start_v;
    logic [15:0] in_data;
    logic        in_valid;

    logic [2:0]  rdy_v, we_v, busy_v, done_v;
    logic [6:0]  waddr_v [3];
    logic [79:0] wdata_v [3];

    w7_ram_loader #(.DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_v[0]),
        .w7_we(we_v[0]), .w7_waddr(waddr_v[0]), .w7_wdata(wdata_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    w7_ram_loader #(.DEPTH(120)) u_d120 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_v[1]),
        .w7_we(we_v[1]), .w7_waddr(waddr_v[1]), .w7_wdata(wdata_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    w7_ram_loader #(.DEPTH(128)) u_d128 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_v[2]),
        .w7_we(we_v[2]), .w7_waddr(waddr_v[2]), .w7_wdata(wdata_v[2]),
        .busy(busy_v[2]), .done(done_v[2])
    );

    logic [1:0]  sel;
    logic        cur_rdy, cur_we, cur_busy, cur_done;
    logic [6:0]  cur_waddr;
    logic [79:0] cur_wdata;

    always_comb begin
        cur_rdy   = rdy_v[sel];
        cur_we    = we_v[sel];
        cur_busy  = busy_v[sel];
        cur_done  = done_v[sel];
        cur_waddr = waddr_v[sel];
        cur_wdata = wdata_v[sel];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected row r when the stream carries base+index.
    function automatic logic [79:0] row_exp(input int r, input logic [15:0] base);
        logic [79:0] v;
        v = '0;
        for (int j = 0; j < 5; j++) v[j*16 +: 16] = base + 16'(5*r + j);
        return v;
    endfunction

    // Write monitor / RAM model for the selected instance.
    int          cyc = 0, nwr = 0, ndone = 0, last_cyc = 0;
    int          addr_bad = 0, rdy_bad = 0, gap_bad = 0;
    int          clear_gen = 0, seen_gen = 0;
    bit          cont = 1'b0;
    logic [6:0]  last_addr = '0;
    logic [79:0] mem [128];

    always @(negedge clk) begin
        cyc++;
        if (clear_gen != seen_gen) begin
            seen_gen = clear_gen;
            nwr = 0; ndone = 0; addr_bad = 0; rdy_bad = 0; gap_bad = 0;
            last_addr = '0;
            for (int i = 0; i < 128; i++) mem[i] = '0;
        end
        if (cur_we) begin
            if (cur_waddr != 7'(nwr)) addr_bad++;
            if (cur_rdy) rdy_bad++;
            if (cont && nwr > 0 && (cyc - last_cyc) != 6) gap_bad++;
            mem[cur_waddr] = cur_wdata;
            last_addr = cur_waddr;
            last_cyc = cyc;
            nwr++;
        end
        if (cur_done) ndone++;
    end

    task automatic mon_reset();
        clear_gen++;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v = '0;
    endtask

    // Offer n words base..base+n-1; gaps idles in_valid ~30% of cycles,
    // poke randomly raises start while the load is in progress.
    task automatic feed(input int n, input logic [15:0] base, input bit gaps, input bit poke);
        int idx = 0;
        int guard = 0;
        bit v, acc;
        while (idx < n && guard < n*4 + 50) begin
            @(negedge clk);
            v = gaps ? ($urandom_range(0, 99) >= 30) : 1'b1;
            in_valid = v;
            in_data  = base + 16'(idx);
            if (poke) start_v[sel] = ($urandom_range(0, 2) == 0);
            acc = v && cur_rdy;
            @(posedge clk);
            if (acc) idx++;
            guard++;
        end
        chk("feed_complete", 80'(idx), 80'(n));
        @(negedge clk);
        in_valid = 1'b0;
        start_v  = '0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (ndone == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 80'(ndone != 0), 80'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_in_ready"}, 80'(cur_rdy),  80'd0);
        chk({t, "_we"},       80'(cur_we),   80'd0);
        chk({t, "_waddr"},    80'(cur_waddr), 80'd0);
        chk({t, "_wdata"},    cur_wdata,     80'd0);
        chk({t, "_busy"},     80'(cur_busy), 80'd0);
        chk({t, "_done"},     80'(cur_done), 80'd0);
    endtask

    task automatic chk_full(input string t, input int rows, input bit gap_check);
        int bad_rows = 0;
        chk({t, "_nwrites"},   80'(nwr), 80'(rows));
        chk({t, "_last_addr"}, 80'(last_addr), 80'(rows - 1));
        chk({t, "_addr_seq"},  80'(addr_bad), 80'd0);
        chk({t, "_rdy_in_write"}, 80'(rdy_bad), 80'd0);
        if (gap_check) chk({t, "_write_spacing"}, 80'(gap_bad), 80'd0);
        chk({t, "_done_count"}, 80'(ndone), 80'd1);
        chk({t, "_busy_after"}, 80'(cur_busy), 80'd0);
        for (int r = 0; r < rows; r++) if (mem[r] !== row_exp(r, 16'h0)) bad_rows++;
        chk({t, "_bad_rows"}, 80'(bad_rows), 80'd0);
        chk({t, "_row0"},    mem[0], row_exp(0, 16'h0));
        chk({t, "_rowlast"}, mem[rows-1], row_exp(rows - 1, 16'h0));
    endtask

    initial begin
        rst_n = 1'b0; start_v = '0; in_valid = 1'b0; in_data = '0; sel = 2'd1;
        repeat (2) @(negedge clk);

        // Reset state.
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // DEPTH=1: idle ignores in_valid, start+valid same cycle, single row.
        sel = 2'd0;
        mon_reset();
        in_valid = 1'b1; in_data = 16'hBEEF;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 80'(cur_rdy), 80'd0);
        chk("idle_busy", 80'(cur_busy), 80'd0);
        start_v[0] = 1'b1; in_data = 16'hDEAD;
        @(negedge clk);
        start_v = '0; in_valid = 1'b0;
        chk("load_in_ready", 80'(cur_rdy), 80'd1);
        chk("load_busy", 80'(cur_busy), 80'd1);
        feed(5, 16'h0001, 1'b0, 1'b0);
        chk("d1_we", 80'(cur_we), 80'd1);
        chk("d1_waddr", 80'(cur_waddr), 80'd0);
        chk("d1_wdata", cur_wdata, 80'h0005_0004_0003_0002_0001);
        chk("d1_rdy_in_write", 80'(cur_rdy), 80'd0);
        chk("d1_done_early", 80'(cur_done), 80'd0);
        @(negedge clk);
        chk("d1_done", 80'(cur_done), 80'd1);
        chk("d1_busy_in_done", 80'(cur_busy), 80'd1);
        chk("d1_we_after", 80'(cur_we), 80'd0);
        chk("d1_wdata_hold", cur_wdata, 80'h0005_0004_0003_0002_0001);
        @(negedge clk);
        chk("d1_done_pulse", 80'(cur_done), 80'd0);
        chk("d1_busy_drop", 80'(cur_busy), 80'd0);
        chk("d1_nwrites", 80'(nwr), 80'd1);

        // DEPTH=120, continuous stream.
        sel = 2'd1; cont = 1'b1;
        mon_reset();
        pulse_start();
        feed(600, 16'h0000, 1'b0, 1'b0);
        wait_done(20);
        chk_full("cont", 120, 1'b1);

        // DEPTH=120, ~30% idle gaps, start poked during LOAD/WRITE.
        cont = 1'b0;
        mon_reset();
        pulse_start();
        feed(600, 16'h0000, 1'b1, 1'b1);
        wait_done(20);
        chk_full("gaps", 120, 1'b0);
        repeat (10) @(negedge clk);
        chk("gaps_no_restart", 80'(cur_busy), 80'd0);

        // Reset after 3 words of row 2, then reload from address 0.
        mon_reset();
        pulse_start();
        feed(13, 16'h0000, 1'b0, 1'b0);
        chk("mid_busy", 80'(cur_busy), 80'd1);
        chk("mid_rdy", 80'(cur_rdy), 80'd1);
        chk("mid_nwrites", 80'(nwr), 80'd2);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_no_write", 80'(nwr), 80'd2);
        mon_reset();
        pulse_start();
        feed(5, 16'h0100, 1'b0, 1'b0);
        chk("reload_we", 80'(cur_we), 80'd1);
        chk("reload_waddr", 80'(cur_waddr), 80'd0);
        chk("reload_wdata", cur_wdata, row_exp(0, 16'h0100));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // DEPTH=128: last address all-ones, no wrap to 0.
        sel = 2'd2; cont = 1'b1;
        mon_reset();
        pulse_start();
        feed(640, 16'h0000, 1'b0, 1'b0);
        wait_done(20);
        repeat (10) @(negedge clk);
        chk_full("d128", 128, 1'b1);
        chk("d128_last_is_7f", 80'(last_addr), 80'h7F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
